// File: rtl/mcu_target_router_pkg.sv
// Shared definitions for the MCU target router: target ids, FSM encodings
// and the start-byte id range check.
package mcu_target_router_pkg;

    localparam logic [7:0] TGT_SYS = 8'd1;
    localparam logic [7:0] TGT_HID = 8'd2;
    localparam logic [7:0] TGT_OSD = 8'd3;
    localparam logic [7:0] TGT_SDC = 8'd4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ROUTE   = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Full 8-bit compare so ids above the target count never alias onto a valid index.
    function automatic logic id_in_range(input logic [7:0] id, input int unsigned n);
        return (id >= TGT_SYS) && ({24'd0, id} <= n);
    endfunction

endpackage

// File: rtl/mcu_target_router_frame_watchdog.sv
// Idle-clock watchdog for an open frame: clears on clr or when disabled,
// saturates at TIMEOUT_CYCLES and pulses expire on the clock it gets there.
module mcu_target_router_frame_watchdog #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clr || !en) begin
            cnt_d = 24'd0;
        end else if ((TIMEOUT_CYCLES != 24'd0) && (cnt_q != TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + 24'd1;
        end
        // A timeout of zero disables the abort entirely.
        if ((TIMEOUT_CYCLES != 24'd0) && en && !clr && (cnt_q == TIMEOUT_CYCLES - 24'd1)) begin
            expire = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mcu_target_router.sv
// Splits the MCU SPI byte stream between command targets by a leading id byte,
// muxes the selected target's reply back and merges target interrupts.
//
//   state   | meaning
//   IDLE    | no frame open
//   ROUTE   | frame open, data bytes go to target sel
//   DISCARD | frame open with an invalid id, data bytes dropped
module mcu_target_router
    import mcu_target_router_pkg::*;
#(
    parameter int          NUM_TARGETS    = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter logic [7:0]  UNKNOWN_RESP   = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mcu_strobe,
    input  logic                       mcu_start,
    input  logic [7:0]                 mcu_din,
    output logic [7:0]                 mcu_dout,
    output logic [NUM_TARGETS-1:0]     tgt_strobe,
    output logic [NUM_TARGETS-1:0]     tgt_start,
    output logic [7:0]                 tgt_din,
    input  logic [8*NUM_TARGETS-1:0]   tgt_dout,
    input  logic [NUM_TARGETS-1:0]     tgt_int,
    output logic                       int_out_n,
    output logic                       frame_error
);

    localparam int SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    logic [1:0]             state_q,       state_d;
    logic [SEL_W-1:0]       sel_q,         sel_d;
    logic                   first_q,       first_d;
    logic [7:0]             mcu_dout_q,    mcu_dout_d;
    logic [NUM_TARGETS-1:0] tgt_strobe_q,  tgt_strobe_d;
    logic [NUM_TARGETS-1:0] tgt_start_q,   tgt_start_d;
    logic [7:0]             tgt_din_q,     tgt_din_d;
    logic                   int_out_n_q,   int_out_n_d;
    logic                   frame_error_q, frame_error_d;
    logic                   wd_expire;

    mcu_target_router_frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (reset),
        .clr    (mcu_strobe),
        .en     (state_q != ST_IDLE),
        .expire (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        first_d       = first_q;
        tgt_strobe_d  = '0;
        tgt_start_d   = '0;
        tgt_din_d     = tgt_din_q;
        frame_error_d = 1'b0;

        // A strobe always beats a watchdog expiry in the same clock.
        if (mcu_strobe && mcu_start) begin
            if (id_in_range(mcu_din, NUM_TARGETS)) begin
                state_d = ST_ROUTE;
                sel_d   = SEL_W'(mcu_din - 8'd1);
                first_d = 1'b1;
            end else begin
                state_d       = ST_DISCARD;
                frame_error_d = 1'b1;
            end
        end else if (mcu_strobe) begin
            if (state_q == ST_ROUTE) begin
                tgt_strobe_d[sel_q] = 1'b1;
                tgt_start_d[sel_q]  = first_q;
                tgt_din_d           = mcu_din;
                first_d             = 1'b0;
            end
        end else if (wd_expire) begin
            state_d       = ST_IDLE;
            frame_error_d = 1'b1;
        end
    end

    always_comb begin
        mcu_dout_d = 8'h00;
        case (state_q)
            ST_ROUTE:   mcu_dout_d = tgt_dout[8*int'(sel_q) +: 8];
            ST_DISCARD: mcu_dout_d = UNKNOWN_RESP;
            default:    mcu_dout_d = 8'h00;
        endcase
        int_out_n_d = ~|tgt_int;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            first_q       <= 1'b0;
            mcu_dout_q    <= 8'h00;
            tgt_strobe_q  <= '0;
            tgt_start_q   <= '0;
            tgt_din_q     <= 8'h00;
            int_out_n_q   <= 1'b1;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            first_q       <= first_d;
            mcu_dout_q    <= mcu_dout_d;
            tgt_strobe_q  <= tgt_strobe_d;
            tgt_start_q   <= tgt_start_d;
            tgt_din_q     <= tgt_din_d;
            int_out_n_q   <= int_out_n_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign mcu_dout    = mcu_dout_q;
    assign tgt_strobe  = tgt_strobe_q;
    assign tgt_start   = tgt_start_q;
    assign tgt_din     = tgt_din_q;
    assign int_out_n   = int_out_n_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_mcu_target_router.sv
// Directed bench for mcu_target_router with a small sysctrl reply model on target 0
// and fixed reply bytes on the other targets.
module tb_mcu_target_router;
    import mcu_target_router_pkg::*;

    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mcu_strobe;
    logic          mcu_start;
    logic [7:0]    mcu_din;
    logic [7:0]    mcu_dout;
    logic [NT-1:0] tgt_strobe;
    logic [NT-1:0] tgt_start;
    logic [7:0]    tgt_din;
    logic [8*NT-1:0] tgt_dout;
    logic [NT-1:0] tgt_int;
    logic          int_out_n;
    logic          frame_error;

    logic [7:0]    sys_reply;
    int            sys_idx;
    int            err_pulses = 0;
    int            vec = 0;
    int            errs = 0;

    always #5 clk = ~clk;

    mcu_target_router #(
        .NUM_TARGETS    (NT),
        .TIMEOUT_CYCLES (24'd16),
        .UNKNOWN_RESP   (8'hFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mcu_strobe  (mcu_strobe),
        .mcu_start   (mcu_start),
        .mcu_din     (mcu_din),
        .mcu_dout    (mcu_dout),
        .tgt_strobe  (tgt_strobe),
        .tgt_start   (tgt_start),
        .tgt_din     (tgt_din),
        .tgt_dout    (tgt_dout),
        .tgt_int     (tgt_int),
        .int_out_n   (int_out_n),
        .frame_error (frame_error)
    );

    assign tgt_dout = {8'hD4, 8'hC3, 8'hB2, sys_reply};

    function automatic logic [7:0] sys_tbl(input int i);
        case (i)
            0:       return 8'h5C;
            1:       return 8'h42;
            2:       return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    // sysctrl model: presents the next reply byte after each strobe
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sys_reply <= 8'h00;
            sys_idx   <= 0;
        end else if (tgt_strobe[0]) begin
            if (tgt_start[0]) begin
                sys_reply <= sys_tbl(0);
                sys_idx   <= 1;
            end else begin
                sys_reply <= sys_tbl(sys_idx);
                sys_idx   <= sys_idx + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (frame_error === 1'b1) err_pulses <= err_pulses + 1;
    end

    task automatic send(input logic s, input logic [7:0] d);
        @(posedge clk);
        #1;
        mcu_strobe = 1'b1;
        mcu_start  = s;
        mcu_din    = d;
        @(posedge clk);
        #1;
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if (mcu_dout !== 8'h00 || tgt_strobe !== 4'b0000 || tgt_start !== 4'b0000 ||
            tgt_din !== 8'h00 || int_out_n !== 1'b1 || frame_error !== 1'b0) begin
            errs++;
            $display("FAIL reset_values got dout=%h strobe=%b start=%b din=%h int_n=%b err=%b",
                     mcu_dout, tgt_strobe, tgt_start, tgt_din, int_out_n, frame_error);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_sysctrl_frame();
        logic [7:0] exp_reply;
        send(1'b1, TGT_SYS);
        vec++;
        if (tgt_strobe !== 4'b0000) begin
            errs++;
            $display("FAIL t1_start_not_forwarded got %b exp 0000", tgt_strobe);
        end
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'h00);
            vec++;
            if (tgt_strobe !== 4'b0001 || tgt_start !== {3'b000, (i == 0)} || tgt_din !== 8'h00) begin
                errs++;
                $display("FAIL t1_byte%0d got strobe=%b start=%b din=%h exp strobe=0001 start=%b din=00",
                         i, tgt_strobe, tgt_start, tgt_din, {3'b000, (i == 0)});
            end
            idle(2);
            exp_reply = sys_tbl(i);
            vec++;
            if (mcu_dout !== exp_reply) begin
                errs++;
                $display("FAIL t1_reply%0d got %h exp %h", i, mcu_dout, exp_reply);
            end
        end
    endtask

    task automatic test_route_osd();
        send(1'b1, TGT_OSD);
        send(1'b0, 8'hA5);
        vec++;
        if (tgt_strobe !== 4'b0100 || tgt_start !== 4'b0100 || tgt_din !== 8'hA5) begin
            errs++;
            $display("FAIL t2_route got strobe=%b start=%b din=%h exp 0100 0100 a5",
                     tgt_strobe, tgt_start, tgt_din);
        end
        idle(1);
        vec++;
        if (tgt_strobe !== 4'b0000 || mcu_dout !== 8'hC3) begin
            errs++;
            $display("FAIL t2_after got strobe=%b dout=%h exp 0000 c3", tgt_strobe, mcu_dout);
        end
    endtask

    task automatic test_invalid_id();
        logic [7:0] ids [3];
        int e0;
        ids[0] = 8'h00;
        ids[1] = 8'h05;
        ids[2] = 8'h07;
        for (int k = 0; k < 3; k++) begin
            e0 = err_pulses;
            send(1'b1, ids[k]);
            vec++;
            if (frame_error !== 1'b1) begin
                errs++;
                $display("FAIL t3_err_pulse id=%h got %b exp 1", ids[k], frame_error);
            end
            idle(1);
            vec++;
            if (frame_error !== 1'b0 || mcu_dout !== 8'hFF) begin
                errs++;
                $display("FAIL t3_discard id=%h got err=%b dout=%h exp 0 ff", ids[k], frame_error, mcu_dout);
            end
            for (int b = 0; b < 2; b++) begin
                send(1'b0, 8'h5A);
                vec++;
                if (tgt_strobe !== 4'b0000 || mcu_dout !== 8'hFF) begin
                    errs++;
                    $display("FAIL t3_drop id=%h byte%0d got strobe=%b dout=%h exp 0000 ff",
                             ids[k], b, tgt_strobe, mcu_dout);
                end
            end
            vec++;
            if (err_pulses - e0 !== 1) begin
                errs++;
                $display("FAIL t3_err_count id=%h got %0d exp 1", ids[k], err_pulses - e0);
            end
        end
    endtask

    task automatic test_watchdog();
        int e0;
        e0 = err_pulses;
        send(1'b1, TGT_HID);
        send(1'b0, 8'h11);
        vec++;
        if (tgt_strobe !== 4'b0010) begin
            errs++;
            $display("FAIL t4_byte got %b exp 0010", tgt_strobe);
        end
        idle(15);
        vec++;
        if (frame_error !== 1'b0) begin
            errs++;
            $display("FAIL t4_early_err got %b exp 0", frame_error);
        end
        idle(1);
        vec++;
        if (frame_error !== 1'b1) begin
            errs++;
            $display("FAIL t4_timeout got %b exp 1", frame_error);
        end
        idle(1);
        vec++;
        if (mcu_dout !== 8'h00) begin
            errs++;
            $display("FAIL t4_idle_dout got %h exp 00", mcu_dout);
        end
        send(1'b0, 8'h22);
        vec++;
        if (tgt_strobe !== 4'b0000 || err_pulses - e0 !== 1) begin
            errs++;
            $display("FAIL t4_dropped got strobe=%b errs=%0d exp 0000 1", tgt_strobe, err_pulses - e0);
        end

        e0 = err_pulses;
        send(1'b1, TGT_HID);
        send(1'b0, 8'h33);
        idle(14);
        send(1'b0, 8'h44);
        vec++;
        if (tgt_strobe !== 4'b0010 || tgt_din !== 8'h44 || frame_error !== 1'b0) begin
            errs++;
            $display("FAIL t4_race got strobe=%b din=%h err=%b exp 0010 44 0", tgt_strobe, tgt_din, frame_error);
        end
        idle(2);
        vec++;
        if (mcu_dout !== 8'hB2 || err_pulses - e0 !== 0) begin
            errs++;
            $display("FAIL t4_race_after got dout=%h errs=%0d exp b2 0", mcu_dout, err_pulses - e0);
        end
    endtask

    task automatic test_restart();
        int e0;
        e0 = err_pulses;
        send(1'b1, TGT_HID);
        send(1'b0, 8'h01);
        vec++;
        if (tgt_strobe !== 4'b0010) begin
            errs++;
            $display("FAIL t5_first got %b exp 0010", tgt_strobe);
        end
        send(1'b1, TGT_SDC);
        vec++;
        if (tgt_strobe !== 4'b0000 || frame_error !== 1'b0) begin
            errs++;
            $display("FAIL t5_restart got strobe=%b err=%b exp 0000 0", tgt_strobe, frame_error);
        end
        send(1'b0, 8'h77);
        vec++;
        if (tgt_strobe !== 4'b1000 || tgt_start !== 4'b1000 || tgt_din !== 8'h77 || err_pulses - e0 !== 0) begin
            errs++;
            $display("FAIL t5_new_target got strobe=%b start=%b din=%h errs=%0d exp 1000 1000 77 0",
                     tgt_strobe, tgt_start, tgt_din, err_pulses - e0);
        end
    endtask

    task automatic test_int_and_reset();
        @(posedge clk);
        #1;
        tgt_int = 4'b0010;
        vec++;
        if (int_out_n !== 1'b1) begin
            errs++;
            $display("FAIL t6_int_latency got %b exp 1", int_out_n);
        end
        idle(1);
        vec++;
        if (int_out_n !== 1'b0) begin
            errs++;
            $display("FAIL t6_int_assert got %b exp 0", int_out_n);
        end
        tgt_int = 4'b0000;
        idle(1);
        vec++;
        if (int_out_n !== 1'b1) begin
            errs++;
            $display("FAIL t6_int_clear got %b exp 1", int_out_n);
        end

        send(1'b1, TGT_SYS);
        tgt_int = 4'b1000;
        send(1'b0, 8'h99);
        vec++;
        if (tgt_strobe !== 4'b0001 || int_out_n !== 1'b0) begin
            errs++;
            $display("FAIL t6_pre_reset got strobe=%b int_n=%b exp 0001 0", tgt_strobe, int_out_n);
        end
        #1 reset = 1'b1;
        #1;
        vec++;
        if (mcu_dout !== 8'h00 || tgt_strobe !== 4'b0000 || tgt_start !== 4'b0000 ||
            tgt_din !== 8'h00 || int_out_n !== 1'b1 || frame_error !== 1'b0) begin
            errs++;
            $display("FAIL t6_async_reset got dout=%h strobe=%b start=%b din=%h int_n=%b err=%b",
                     mcu_dout, tgt_strobe, tgt_start, tgt_din, int_out_n, frame_error);
        end
        tgt_int = 4'b0000;
        #2 reset = 1'b0;
        send(1'b0, 8'h55);
        vec++;
        if (tgt_strobe !== 4'b0000) begin
            errs++;
            $display("FAIL t6_idle_after_reset got %b exp 0000", tgt_strobe);
        end
        idle(1);
        vec++;
        if (mcu_dout !== 8'h00) begin
            errs++;
            $display("FAIL t6_idle_dout got %h exp 00", mcu_dout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL time_limit simulation did not complete, got timeout exp finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset      = 1'b1;
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
        mcu_din    = 8'h00;
        tgt_int    = '0;
        test_reset();
        test_sysctrl_frame();
        test_route_osd();
        test_invalid_id();
        test_watchdog();
        test_restart();
        test_int_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
